// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_if : imem req/ack port, redirect and decode valid/ready bundle
// Rev 1.0
// ============================================================================
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : PC owner, imem word fetch, small instruction FIFO to decode
// Rev 1.0
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input wire logic       clk,
  input wire logic       reset,
  instr_fetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [PW-1:0] c_last  = PW'(DEPTH - 1);
  localparam logic [31:0]   c_nop   = 32'h0000_0013;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_addr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  logic          w_req;
  logic [31:0]   w_addr;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == c_last) ? '0 : p + PW'(1);
  endfunction

  // Request decoded from state only, so imem never sees a combinational input path
  always_comb begin
    w_req  = 1'b0;
    w_addr = r_pc;
    case (r_state)
      S_FETCH: w_req = (r_count < c_depth);
      S_DROP: begin
        w_req  = 1'b1;
        w_addr = r_req_addr;
      end
      default: ;
    endcase
  end

  assign w_push  = (r_state == S_FETCH) && w_req && bus.imem_ack && !bus.redirect;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.instr_ready;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = w_addr;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? r_mem_instr[r_rd_ptr] : c_nop;
  assign bus.instr_pc    = w_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      // DROP keeps the stale address until its ack retires the request
      if (r_state != S_DROP) r_req_addr <= r_pc;
      if (bus.redirect) begin
        r_pc     <= bus.redirect_pc & ~32'd3;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_state  <= (w_req && !bus.imem_ack) ? S_DROP : S_FETCH;
      end else begin
        case (r_state)
          S_IDLE:  r_state <= S_FETCH;
          S_FETCH: if (w_push) r_pc <= r_pc + 32'd4;
          S_DROP:  if (bus.imem_ack) r_state <= S_FETCH;
          default: r_state <= S_IDLE;
        endcase
        if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_pc;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch
// Rev 1.0
// ============================================================================
module tb_instr_fetch;
  localparam logic [31:0] c_xor = 32'hA5A5_0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.imem_rdata = bus.imem_addr ^ c_xor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are registered-only
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   32'(bus.imem_req), 32'h0);
    check({tag, ".addr"},  bus.imem_addr, 32'h0);
    check({tag, ".valid"}, 32'(bus.instr_valid), 32'h0);
    check({tag, ".instr"}, bus.instr, 32'h13);
    check({tag, ".pc"},    bus.instr_pc, 32'h0);
  endtask

  // Leaves the DUT in its first FETCH cycle with all inputs idle
  task automatic do_reset();
    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;

    // 1: reset values before any clock, IDLE cycle, then first request
    #3;
    check_reset_outputs("t1_rst");
    tick();
    reset = 1'b0;
    check("t1_idle_req", 32'(bus.imem_req), 32'h0);
    tick();
    check("t1_req", 32'(bus.imem_req), 32'h1);
    check("t1_addr", bus.imem_addr, 32'h0);

    // 2: streaming, one word per cycle
    bus.imem_ack    = 1'b1;
    bus.instr_ready = 1'b1;
    check("t2_valid0", 32'(bus.instr_valid), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_valid%0d", i), 32'(bus.instr_valid), 32'h1);
      check($sformatf("t2_pc%0d", i), bus.instr_pc, 32'(4 * i));
      check($sformatf("t2_instr%0d", i), bus.instr, 32'(4 * i) ^ c_xor);
      tick();
    end

    // 3: backpressure fills the buffer and stops requests
    do_reset();
    bus.imem_ack = 1'b1;
    tick();
    tick();
    check("t3_full_req", 32'(bus.imem_req), 32'h0);
    check("t3_head0", bus.instr_pc, 32'h0);
    tick();
    check("t3_hold_req", 32'(bus.imem_req), 32'h0);
    check("t3_hold_head", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1;
    tick();
    check("t3_head4", bus.instr_pc, 32'h4);
    check("t3_addr8", bus.imem_addr, 32'h8);
    check("t3_req8", 32'(bus.imem_req), 32'h1);
    tick();
    check("t3_head8", bus.instr_pc, 32'h8);
    check("t3_instr8", bus.instr, 32'h8 ^ c_xor);

    // 4: redirect coinciding with an ack
    do_reset();
    bus.imem_ack    = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    check("t4_head0", bus.instr_pc, 32'h0);
    check("t4_addr4", bus.imem_addr, 32'h4);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    check("t4_flush_valid", 32'(bus.instr_valid), 32'h0);
    check("t4_new_addr", bus.imem_addr, 32'h100);
    tick();
    check("t4_valid", 32'(bus.instr_valid), 32'h1);
    check("t4_pc", bus.instr_pc, 32'h100);

    // 5: redirect while a request is stalled
    do_reset();
    bus.imem_ack    = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    check("t5_addr8", bus.imem_addr, 32'h8);
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h7D0;
    tick();
    bus.redirect = 1'b0;
    check("t5_drop_addr_a", bus.imem_addr, 32'h8);
    check("t5_drop_req", 32'(bus.imem_req), 32'h1);
    check("t5_drop_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    check("t5_drop_addr_b", bus.imem_addr, 32'h8);
    bus.imem_ack = 1'b1;
    tick();
    check("t5_new_addr", bus.imem_addr, 32'h7D0);
    check("t5_no_stale", 32'(bus.instr_valid), 32'h0);
    tick();
    check("t5_pc", bus.instr_pc, 32'h7D0);
    check("t5_instr", bus.instr, 32'h7D0 ^ c_xor);

    // 6: asynchronous reset with a full buffer
    do_reset();
    bus.imem_ack = 1'b1;
    tick();
    tick();
    check("t6_full_valid", 32'(bus.instr_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    tick();
    bus.instr_ready = 1'b1;
    reset           = 1'b0;
    check("t6_idle_valid", 32'(bus.instr_valid), 32'h0);
    check("t6_idle_req", 32'(bus.imem_req), 32'h0);
    tick();
    check("t6_restart_addr", bus.imem_addr, 32'h0);
    check("t6_restart_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    check("t6_restart_pc", bus.instr_pc, 32'h0);

    // 7: low address bits masked, PC wraps past the top of memory
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    check("t7_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("t7_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
    check("t7_wrap_addr", bus.imem_addr, 32'h0);
    tick();
    check("t7_pc_wrap", bus.instr_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
